// File: rtl/keypad_scanner_if.sv
// Key delivery handshake between keypad_scanner (master) and its consumer (slave).
interface keypad_scanner_if;
  logic [3:0] key_code_out;
  logic       key_valid_out;
  logic       key_ready_in;

  modport master (
    output key_code_out,
    output key_valid_out,
    input  key_ready_in
  );

  modport slave (
    input  key_code_out,
    input  key_valid_out,
    output key_ready_in
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with debounce, valid/ready key stream and digit-entry register.
// Optional auto-repeat of a held key is built only when KEYPAD_AUTOREPEAT_EN is defined.
//
// state       | meaning
// ST_SCAN     | drive rows in turn, look for any low column
// ST_DEBOUNCE | row held, counting consecutive low samples of the latched column
// ST_RELEASE  | key confirmed, row held, counting consecutive high samples
module keypad_scanner #(
  parameter int DIGIT_COUNT    = 8,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clke_in,
  input  logic [3:0]               cols_in,
  output logic [3:0]               rows_out,
  keypad_scanner_if.master         key_if,
  input  logic                     clear_in,
  output logic [DIGIT_COUNT*4-1:0] value_out,
  output logic [DIGIT_COUNT-1:0]   mask_out,
  output logic                     overrun_out
);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 || REPEAT_TICKS < 1 || DIGIT_COUNT < 2)
  begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  localparam logic [7:0] DEB_LOAD = 8'(DEBOUNCE_TICKS);

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [7:0] deb_q, deb_d;
  logic [1:0] col_hit;
  logic [1:0] confirm_col;
  logic       any_low;
  logic       col_low;
  logic       confirm;

  logic [3:0]               code_q;
  logic                     valid_q;
  logic [DIGIT_COUNT*4-1:0] value_q;
  logic [DIGIT_COUNT-1:0]   mask_q;
  logic                     overrun_q;
  logic [3:0]               rows_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_TICKS);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  // Lowest-index low column wins when several keys share the driven row.
  always_comb begin
    col_hit = 2'd0;
    if (!cols_in[0])      col_hit = 2'd0;
    else if (!cols_in[1]) col_hit = 2'd1;
    else if (!cols_in[2]) col_hit = 2'd2;
    else if (!cols_in[3]) col_hit = 2'd3;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    deb_d       = deb_q;
    confirm     = 1'b0;
    any_low     = ~&cols_in;
    col_low     = ~cols_in[col_q];
    confirm_col = (state_q == ST_SCAN) ? col_hit : col_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d       = (state_q == ST_RELEASE) ? rpt_q : RPT_LOAD;
`endif
    if (clke_in) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            col_d = col_hit;
            if (DEBOUNCE_TICKS == 1) begin
              confirm = 1'b1;
              state_d = ST_RELEASE;
              deb_d   = DEB_LOAD;
            end else begin
              state_d = ST_DEBOUNCE;
              deb_d   = DEB_LOAD - 8'd1;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (col_low) begin
            if (deb_q == 8'd1) begin
              confirm = 1'b1;
              state_d = ST_RELEASE;
              deb_d   = DEB_LOAD;
            end else begin
              deb_d = deb_q - 8'd1;
            end
          end else begin
            state_d = ST_SCAN;
            row_d   = row_q + 2'd1;
          end
        end
        ST_RELEASE: begin
          if (!col_low) begin
            if (deb_q == 8'd1) begin
              state_d = ST_SCAN;
              row_d   = row_q + 2'd1;
            end else begin
              deb_d = deb_q - 8'd1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_d = RPT_LOAD;
`endif
          end else begin
            deb_d = DEB_LOAD;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rpt_q == RPT_W'(1)) begin
              confirm = 1'b1;
              rpt_d   = RPT_LOAD;
            end else begin
              rpt_d = rpt_q - RPT_W'(1);
            end
`endif
          end
        end
        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_SCAN;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      deb_q   <= 8'd0;
      rows_q  <= 4'hE;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      deb_q   <= deb_d;
      rows_q  <= ~(4'b0001 << row_d);
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  // A same-cycle consume frees the slot, so a confirm then loads instead of overrunning.
  // Clear is applied last so it overrides a same-cycle shift or overrun.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      value_q   <= '0;
      mask_q    <= '1;
      overrun_q <= 1'b0;
    end else begin
      if (valid_q && key_if.key_ready_in) begin
        valid_q <= 1'b0;
      end
      if (confirm) begin
        if (!valid_q || key_if.key_ready_in) begin
          code_q  <= {row_q, confirm_col};
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
        value_q <= {value_q[DIGIT_COUNT*4-5:0], row_q, confirm_col};
        mask_q  <= {mask_q[DIGIT_COUNT-2:0], 1'b0};
      end
      if (clear_in) begin
        value_q   <= '0;
        mask_q    <= '1;
        overrun_q <= 1'b0;
      end
    end
  end

  assign key_if.key_code_out  = code_q;
  assign key_if.key_valid_out = valid_q;
  assign rows_out             = rows_q;
  assign value_out            = value_q;
  assign mask_out             = mask_q;
  assign overrun_out          = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model, scoreboard of expected key codes.
module tb_keypad_scanner;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        clke_in;
  logic [3:0]  cols_in;
  logic [3:0]  rows_out;
  logic        clear_in;
  logic [31:0] value_out;
  logic [7:0]  mask_out;
  logic        overrun_out;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .DIGIT_COUNT(8),
    .DEBOUNCE_TICKS(4),
    .REPEAT_TICKS(64)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .clke_in(clke_in),
    .cols_in(cols_in),
    .rows_out(rows_out),
    .key_if(kif.master),
    .clear_in(clear_in),
    .value_out(value_out),
    .mask_out(mask_out),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Matrix model: the pressed key pulls its column low only while its row is driven.
  logic       pressed;
  logic [1:0] prow, pcol;
  always_comb begin
    cols_in = 4'hF;
    if (pressed && rows_out[prow] == 1'b0) cols_in = ~(4'b0001 << pcol);
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int n_emit = 0;
  logic [4:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs only change just after a rising edge, so valid&&ready seen here is the next transfer.
  always @(negedge clk_in) begin
    if (kif.key_valid_out === 1'b1 && kif.key_ready_in === 1'b1) begin
      logic [4:0] exp;
      exp = (sb.size() > 0) ? sb.pop_front() : 5'h10;
      n_emit++;
      n_cmp++;
      assert ({1'b0, kif.key_code_out} === exp)
      else begin
        n_fail++;
        $error("FAIL emit_code: observed %h expected %h", {1'b0, kif.key_code_out}, exp);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in); #1; clke_in = 1'b1;
    @(posedge clk_in); #1; clke_in = 1'b0;
    repeat (2) begin @(posedge clk_in); #1; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_row(input int r);
    int n;
    n = 0;
    while (rows_out[r] !== 1'b0 && n < 8) begin
      tick();
      n++;
    end
    chk("wait_row", {31'b0, rows_out[r]}, 32'h0);
  endtask

  task automatic set_key(input int code);
    prow = 2'(code / 4);
    pcol = 2'(code % 4);
  endtask

  task automatic press_hold_release(input int code, input int hold);
    set_key(code);
    wait_row(code / 4);
    pressed = 1'b1;
    ticks(hold);
    pressed = 1'b0;
    ticks(6);
  endtask

  task automatic pulse_clear();
    @(posedge clk_in); #1; clear_in = 1'b1;
    @(posedge clk_in); #1; clear_in = 1'b0;
  endtask

  int base;
  int exp_rep;

  initial begin
    rst_in = 1'b1; clke_in = 1'b0; clear_in = 1'b0; pressed = 1'b0;
    prow = 2'd0; pcol = 2'd0; kif.key_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    chk("rst_rows",    {28'b0, rows_out}, 32'hE);
    chk("rst_valid",   {31'b0, kif.key_valid_out}, 32'h0);
    chk("rst_code",    {28'b0, kif.key_code_out}, 32'h0);
    chk("rst_value",   value_out, 32'h0);
    chk("rst_mask",    {24'b0, mask_out}, 32'hFF);
    chk("rst_overrun", {31'b0, overrun_out}, 32'h0);

    // Idle scan rotation
    tick(); chk("scan_d", {28'b0, rows_out}, 32'hD);
    tick(); chk("scan_b", {28'b0, rows_out}, 32'hB);
    tick(); chk("scan_7", {28'b0, rows_out}, 32'h7);
    tick(); chk("scan_e", {28'b0, rows_out}, 32'hE);
    chk("idle_valid", {31'b0, kif.key_valid_out}, 32'h0);
    chk("idle_mask",  {24'b0, mask_out}, 32'hFF);

    // Row 2 / col 1: confirmation lands on the fourth tick
    base = n_emit;
    set_key(9);
    wait_row(2);
    sb.push_back(5'h09);
    pressed = 1'b1;
    ticks(3);
    chk("deb_early", n_emit - base, 0);
    chk("deb_early_mask", {24'b0, mask_out}, 32'hFF);
    tick();
    chk("deb_emit", n_emit - base, 1);
    chk("deb_valid_drop", {31'b0, kif.key_valid_out}, 32'h0);
    ticks(2);
    pressed = 1'b0;
    ticks(6);
    chk("k9_value", value_out, 32'h9);
    chk("k9_mask",  {24'b0, mask_out}, 32'hFE);
    chk("k9_count", n_emit - base, 1);

    // Bounce: low 2, high 1, low 2 gives nothing; stable low gives one key
    base = n_emit;
    set_key(6);
    wait_row(1);
    pressed = 1'b1; ticks(2);
    pressed = 1'b0; tick();
    pressed = 1'b1; ticks(2);
    chk("bounce_none", n_emit - base, 0);
    sb.push_back(5'h06);
    ticks(12);
    pressed = 1'b0;
    ticks(6);
    chk("bounce_one", n_emit - base, 1);
    chk("bounce_value", value_out, 32'h96);

    // Overrun with ready low, then clear
    pulse_clear();
    chk("clr0_value", value_out, 32'h0);
    kif.key_ready_in = 1'b0;
    base = n_emit;
    sb.push_back(5'h03);
    press_hold_release(3, 6);
    press_hold_release(5, 6);
    chk("ovr_valid",   {31'b0, kif.key_valid_out}, 32'h1);
    chk("ovr_code",    {28'b0, kif.key_code_out}, 32'h3);
    chk("ovr_flag",    {31'b0, overrun_out}, 32'h1);
    chk("ovr_value",   value_out, 32'h35);
    chk("ovr_mask",    {24'b0, mask_out}, 32'hFC);
    pulse_clear();
    chk("clr_value",   value_out, 32'h0);
    chk("clr_mask",    {24'b0, mask_out}, 32'hFF);
    chk("clr_overrun", {31'b0, overrun_out}, 32'h0);
    chk("clr_valid",   {31'b0, kif.key_valid_out}, 32'h1);
    chk("clr_code",    {28'b0, kif.key_code_out}, 32'h3);

    // Key 3 consumed on the same edge key 7 confirms
    sb.push_back(5'h07);
    set_key(7);
    wait_row(1);
    pressed = 1'b1;
    ticks(3);
    chk("cc_pending", n_emit - base, 0);
    @(posedge clk_in); #1; clke_in = 1'b1; kif.key_ready_in = 1'b1;
    @(posedge clk_in); #1; clke_in = 1'b0;
    repeat (2) begin @(posedge clk_in); #1; end
    chk("cc_emits",   n_emit - base, 2);
    chk("cc_overrun", {31'b0, overrun_out}, 32'h0);
    chk("cc_value",   value_out, 32'h7);
    pressed = 1'b0;
    ticks(6);

    // Nine presses wrap the entry register
    pulse_clear();
    base = n_emit;
    for (int k = 1; k <= 9; k++) begin
      sb.push_back(5'(k));
      press_hold_release(k, 5);
    end
    chk("wrap_value", value_out, 32'h23456789);
    chk("wrap_mask",  {24'b0, mask_out}, 32'h00);
    chk("wrap_count", n_emit - base, 9);

    // Asynchronous reset during debounce
    base = n_emit;
    set_key(12);
    wait_row(3);
    pressed = 1'b1;
    ticks(2);
    rst_in = 1'b1;
    #1;
    chk("arst_rows",    {28'b0, rows_out}, 32'hE);
    chk("arst_valid",   {31'b0, kif.key_valid_out}, 32'h0);
    chk("arst_value",   value_out, 32'h0);
    chk("arst_mask",    {24'b0, mask_out}, 32'hFF);
    chk("arst_overrun", {31'b0, overrun_out}, 32'h0);
    pressed = 1'b0;
    @(posedge clk_in); #1 rst_in = 1'b0;
    ticks(8);
    chk("arst_no_emit", n_emit - base, 0);

    // Held key A for 200 ticks after confirmation
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    base = n_emit;
    for (int i = 0; i < exp_rep; i++) sb.push_back(5'h0A);
    set_key(10);
    wait_row(2);
    pressed = 1'b1;
    ticks(4 + 200);
    pressed = 1'b0;
    ticks(6);
    chk("hold_emits", n_emit - base, exp_rep);

    repeat (4) @(posedge clk_in);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 hex keypad matrix and debounces key presses.
- Delivers each confirmed key as a 4-bit code on a valid/ready handshake.
- Also shifts confirmed keys into a digit-entry register whose value/mask outputs feed the seven-segment display's value and mask inputs directly.
- Input-side counterpart of the display path; sits between board pins and the CPU I/O space.

## Interface
- DIGIT_COUNT, 8, digits in entry register; must equal the display's segment count.
- DEBOUNCE_TICKS, 4, consecutive stable samples needed for press/release confirmation; legal range 1..255.
- REPEAT_TICKS, 64, auto-repeat period in ticks; used only with KEYPAD_AUTOREPEAT_EN.
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- clke_in  in  1  scan tick enable; FSM, row and counters advance only when high
- cols_in  in  4  column sense, active-low (pulled up externally)
- rows_out  out  4  row drive, active-low, exactly one bit low
- key_code_out  out  4  confirmed key code = row*4 + col
- key_valid_out  out  1  key_code_out valid
- key_ready_in  in  1  consumer accepts key
- clear_in  in  1  synchronous clear of entry register and overrun flag
- value_out  out  DIGIT_COUNT*4  entry register; newest digit in bits [3:0]
- mask_out  out  DIGIT_COUNT  1 = digit blank (display mask polarity)
- overrun_out  out  1  sticky: confirmed key dropped because key_valid_out still high

## Operation
- Reset values:
  - rows_out=4'hE (row 0 driven)
  - key_code_out=0, key_valid_out=0
  - value_out=0, mask_out=all ones
  - overrun_out=0
  - state SCAN, row=0, counter=0
- SCAN, on each tick:
  - If any cols_in bit is low, latch row and col (lowest-index low column wins), set counter=1, go to DEBOUNCE. Row is held.
  - Otherwise advance row 0→1→2→3→0.
  - If DEBOUNCE_TICKS=1, confirm immediately (go to RELEASE and emit).
- DEBOUNCE, on each tick:
  - If cols_in[col]=0, counter++; when counter reaches DEBOUNCE_TICKS, confirm and go to RELEASE.
  - If cols_in[col]=1, return to SCAN and advance row. No emit.
- Confirm:
  - value_out <= {value_out[DIGIT_COUNT*4-5:0], code}
  - mask_out <= {mask_out[DIGIT_COUNT-2:0], 1'b0}
  - If key_valid_out=0: load key_code_out, set key_valid_out.
  - Else: key is dropped from the stream, overrun_out set; entry register still shifts.
- RELEASE, on each tick, row held:
  - If cols_in[col]=1, counter++; when counter reaches DEBOUNCE_TICKS, go to SCAN and advance row.
  - Any low sample resets counter to 0.
  - Other keys pressed meanwhile are ignored.
- Handshake (every clk, independent of clke_in):
  - key_valid_out && key_ready_in transfers; valid drops next cycle.
  - key_code_out is stable while valid is high.
  - Ready without valid: no effect.
- clear_in: value_out=0, mask_out=all ones, overrun_out=0.
  - Scan FSM and pending key_valid_out are unaffected.
  - Clear wins over a same-cycle confirm shift; the key is still emitted on the handshake.
- Entry register shifts and wraps: the oldest digit is discarded once all DIGIT_COUNT digits are unmasked.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Press confirmation:
  - Tick t0: first low sample in SCAN.
  - Tick t0+DEBOUNCE_TICKS-1: confirming tick.
  - key_valid_out, value_out and mask_out change at the clk edge of the confirming tick.
- rows_out changes at the clk edge of the tick that advances the row. Columns are sampled on the next tick, giving a full tick of settle time.
- Consume-then-confirm in the same cycle (valid && ready && confirm): new key loads and valid stays high. No overrun.
- rst_in mid-operation: all state returns to reset values immediately (asynchronous); a pending key is lost.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In RELEASE, while cols_in[col]=0, a repeat counter increments per tick.
  - At REPEAT_TICKS, the key is re-confirmed (same emit/shift/overrun rules) and the counter restarts.
  - The repeat counter resets on any high sample.
- Not defined: RELEASE only waits for release; no repeat logic is synthesized and REPEAT_TICKS is ignored.

## Test plan
- Reset, no keys, clke_in every 4 clks → rows_out cycles E,D,B,7,E; key_valid_out=0, mask_out=8'hFF.
- Hold row 2/col 1 low for 6 ticks, ready=1, DEBOUNCE_TICKS=4 → one key_code_out=4'h9 with valid for 1 clk; value_out=32'h9; mask_out=8'hFE.
- Bounce: low 2 ticks, high 1, low 2 → no emit; then stable low → single emit.
- ready=0; press keys 3 then 5 → key_code_out=3 held, overrun_out=1, value_out=32'h35, mask_out=8'hFC; clear_in → value_out=0, mask_out=8'hFF, overrun_out=0, valid still high.
- Nine presses of keys 1..9 → value_out=32'h23456789, mask_out=8'h00.
- Assert rst_in mid-DEBOUNCE → immediate reset values; with KEYPAD_AUTOREPEAT_EN and REPEAT_TICKS=64, hold key A for 200 ticks after confirm → 4 emits total.
